// File: rtl/wb_bridge_pkg.sv
// ============================================================================
// wb_bridge_pkg : shared types and constants for the core-to-Wishbone bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/wishbone_if.sv
// ============================================================================
// wishbone_if : pipelined Wishbone bus bundle with master/slave views
// Revision: 1.0
// ============================================================================
`default_nettype none

interface wishbone_if (
   input wire logic clk_i,
   input wire logic rst_ni
);
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] addr;
   logic [31:0] data_m;
   logic [31:0] data_s;
   logic        ack;
   logic        stall;
   logic        err;

   modport master (
      output cyc, stb, we, sel, addr, data_m,
      input  data_s, ack, stall, err
   );

   modport slave (
      input  clk_i, rst_ni, cyc, stb, we, sel, addr, data_m,
      output data_s, ack, stall, err
   );
endinterface

`default_nettype wire

// File: rtl/core2wb_bridge.sv
// ============================================================================
// core2wb_bridge : core data port to pipelined Wishbone master, one transfer
//                  outstanding, with a WAIT-state timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core2wb_bridge
   import wb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  wire logic        clk_i,
   input  wire logic        rst_ni,
   input  wire logic        data_req_i,
   output      logic        data_gnt_o,
   input  wire logic        data_we_i,
   input  wire logic [3:0]  data_be_i,
   input  wire logic [31:0] data_addr_i,
   input  wire logic [31:0] data_wdata_i,
   output      logic        data_rvalid_o,
   output      logic [31:0] data_rdata_o,
   output      logic        data_err_o,
   wishbone_if.master       wb
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q,  state_d;
   logic        we_q,     we_d;
   logic [3:0]  be_q,     be_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [7:0]  cnt_q,    cnt_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        err_q,    err_d;

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rvalid_d   = 1'b0;
      rdata_d    = rdata_q;
      err_d      = err_q;
      data_gnt_o = 1'b0;

      case (state_q)
         IDLE: begin
            data_gnt_o = data_req_i & rst_ni;
            if (data_req_i) begin
               we_d    = data_we_i;
               be_d    = data_be_i;
               addr_d  = data_addr_i;
               wdata_d = data_wdata_i;
               state_d = REQ;
            end
         end
         REQ: begin
            // A response in the acceptance cycle completes without visiting WAIT.
            if (!wb.stall) begin
               if (wb.ack || wb.err) begin
                  rvalid_d = 1'b1;
                  rdata_d  = wb.data_s;
                  err_d    = wb.err;
                  state_d  = IDLE;
               end else begin
                  cnt_d   = 8'd0;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (wb.ack || wb.err) begin
               rvalid_d = 1'b1;
               rdata_d  = wb.data_s;
               err_d    = wb.err;
               state_d  = IDLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               rvalid_d = 1'b1;
               rdata_d  = 32'd0;
               err_d    = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         be_q     <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         cnt_q    <= 8'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign wb.cyc    = (state_q != IDLE);
   assign wb.stb    = (state_q == REQ);
   assign wb.we     = we_q;
   assign wb.sel    = be_q;
   assign wb.addr   = addr_q;
   assign wb.data_m = wdata_q;

   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;
   assign data_err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_core2wb_bridge.sv
// ============================================================================
// tb_core2wb_bridge : directed bench for core2wb_bridge with a LED slave model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core2wb_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_req = 1'b0;
   logic        data_gnt;
   logic        data_we = 1'b0;
   logic [3:0]  data_be = 4'h0;
   logic [31:0] data_addr = 32'h0;
   logic [31:0] data_wdata = 32'h0;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        data_err;

   always #5 clk = ~clk;

   wishbone_if wb (.clk_i(clk), .rst_ni(rst_n));

   core2wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .data_req_i   (data_req),
      .data_gnt_o   (data_gnt),
      .data_we_i    (data_we),
      .data_be_i    (data_be),
      .data_addr_i  (data_addr),
      .data_wdata_i (data_wdata),
      .data_rvalid_o(data_rvalid),
      .data_rdata_o (data_rdata),
      .data_err_o   (data_err),
      .wb           (wb)
   );

   // LED slave: one-cycle registered ack, optional stall / no-ack / error.
   logic        ack_r = 1'b0;
   logic        err_r = 1'b0;
   logic [31:0] dat_r = 32'h0;
   logic [3:0]  led = 4'hA;
   int          cfg_stall = 0;
   bit          cfg_noack = 1'b0;
   int          cfg_err_at = -1;
   bit          force_ack = 1'b0;
   int          stall_cnt = 0;
   int          accepts = 0;
   int          rv_count = 0;
   logic [3:0]  acc_sel = 4'h0;
   logic [31:0] first_addr = 32'h0;
   logic [31:0] first_data = 32'h0;
   bit          unstable = 1'b0;

   assign wb.stall  = wb.cyc && wb.stb && (stall_cnt < cfg_stall);
   assign wb.ack    = ack_r | force_ack;
   assign wb.err    = err_r;
   assign wb.data_s = dat_r;

   always @(posedge clk) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (!rst_n) begin
         stall_cnt <= 0;
      end else if (wb.cyc && wb.stb) begin
         if (stall_cnt == 0) begin
            first_addr <= wb.addr;
            first_data <= wb.data_m;
         end else if (wb.addr !== first_addr || wb.data_m !== first_data) begin
            unstable <= 1'b1;
         end
         if (wb.stall) begin
            stall_cnt <= stall_cnt + 1;
         end else begin
            stall_cnt <= 0;
            accepts   <= accepts + 1;
            acc_sel   <= wb.sel;
            dat_r     <= {28'h0, led};
            if (wb.we && wb.sel[0]) led <= wb.data_m[3:0];
            if (!cfg_noack) begin
               if (accepts + 1 == cfg_err_at) err_r <= 1'b1;
               else                           ack_r <= 1'b1;
            end
         end
      end
      if (rst_n && data_rvalid) rv_count <= rv_count + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request from posedge+1 and waits (bounded) for rvalid.
   // Latency counts the grant cycle as 0; -1 means no rvalid was seen.
   task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rd, output logic e);
      data_req   = 1'b1;
      data_we    = we;
      data_be    = be;
      data_addr  = addr;
      data_wdata = wdata;
      lat = -1;
      rd  = 32'hx;
      e   = 1'bx;
      @(negedge clk);
      check_val("xfer_gnt", {31'h0, data_gnt}, 32'd1);
      step();
      data_req = 1'b0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (data_rvalid) begin
            lat = c;
            rd  = data_rdata;
            e   = data_err;
            break;
         end
         step();
      end
      if (lat >= 0) step();
   endtask

   int          lat;
   logic [31:0] rd;
   logic        e;
   int          acc0;
   int          rv0;

   initial begin
      // Reset with a pending request: no grant, everything cleared.
      rst_n    = 1'b0;
      data_req = 1'b1;
      repeat (3) step();
      @(negedge clk);
      check_val("rst_gnt",    {31'h0, data_gnt},    32'd0);
      check_val("rst_cyc",    {31'h0, wb.cyc},      32'd0);
      check_val("rst_stb",    {31'h0, wb.stb},      32'd0);
      check_val("rst_sel",    {28'h0, wb.sel},      32'd0);
      check_val("rst_addr",   wb.addr,              32'd0);
      check_val("rst_rvalid", {31'h0, data_rvalid}, 32'd0);
      check_val("rst_rdata",  data_rdata,           32'd0);
      check_val("rst_err",    {31'h0, data_err},    32'd0);
      step();
      data_req = 1'b0;
      rst_n    = 1'b1;
      step();

      // Read of the LED register.
      xfer(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
      check_val("rd_lat",   lat, 32'd3);
      check_val("rd_data",  rd,  32'h0000000A);
      check_val("rd_err",   {31'h0, e}, 32'd0);

      // Write 5 to the LED register, then read it back.
      xfer(1'b1, 4'hF, 32'h0, 32'h5, lat, rd, e);
      check_val("wr_lat",  lat, 32'd3);
      check_val("wr_err",  {31'h0, e}, 32'd0);
      check_val("wr_sel",  {28'h0, acc_sel}, 32'hF);
      check_val("wr_led",  {28'h0, led}, 32'h5);
      xfer(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
      check_val("rb_data", rd, 32'h5);
      repeat (3) step();
      @(negedge clk);
      check_val("rdata_hold", data_rdata, 32'h5);
      step();

      // Four stall cycles: stable strobe, one acceptance, rvalid two cycles later.
      cfg_stall = 4;
      acc0 = accepts;
      xfer(1'b1, 4'hF, 32'h10, 32'h123, lat, rd, e);
      cfg_stall = 0;
      check_val("stall_lat",      lat, 32'd7);
      check_val("stall_err",      {31'h0, e}, 32'd0);
      check_val("stall_accepts",  accepts - acc0, 32'd1);
      check_val("stall_stable",   {31'h0, unstable}, 32'd0);

      // Silent slave: timeout after 8 WAIT cycles, late ack ignored.
      cfg_noack = 1'b1;
      xfer(1'b0, 4'hF, 32'h4, 32'h0, lat, rd, e);
      check_val("to_lat",   lat, 32'd10);
      check_val("to_err",   {31'h0, e}, 32'd1);
      check_val("to_rdata", rd, 32'd0);
      rv0 = rv_count;
      force_ack = 1'b1;
      step();
      force_ack = 1'b0;
      repeat (5) step();
      check_val("late_ack_no_rvalid", rv_count - rv0, 32'd0);

      // Reset while in WAIT: transfer dropped, no rvalid, next transfer normal.
      data_req  = 1'b1;
      data_we   = 1'b0;
      data_addr = 32'h0;
      @(negedge clk);
      check_val("rw_gnt", {31'h0, data_gnt}, 32'd1);
      step();
      data_req = 1'b0;
      step();
      @(negedge clk);
      check_val("rw_in_wait_cyc", {31'h0, wb.cyc & ~wb.stb}, 32'd1);
      step();
      rv0   = rv_count;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("rw_cyc_drop", {31'h0, wb.cyc}, 32'd0);
      check_val("rw_stb_drop", {31'h0, wb.stb}, 32'd0);
      step();
      rst_n     = 1'b1;
      cfg_noack = 1'b0;
      repeat (15) step();
      check_val("rw_no_rvalid", rv_count - rv0, 32'd0);
      xfer(1'b0, 4'hF, 32'h0, 32'h0, lat, rd, e);
      check_val("rw_next_lat",  lat, 32'd3);
      check_val("rw_next_data", rd,  32'h3);

      // Back-to-back with request held high; second transfer gets a bus error.
      cfg_err_at = accepts + 2;
      data_req   = 1'b1;
      data_we    = 1'b0;
      @(negedge clk);
      check_val("b2b_gnt0", {31'h0, data_gnt}, 32'd1);
      step();
      step();
      step();
      @(negedge clk);
      check_val("b2b_rvalid0", {31'h0, data_rvalid}, 32'd1);
      check_val("b2b_gnt1",    {31'h0, data_gnt},    32'd1);
      check_val("b2b_no_cyc",  {31'h0, wb.cyc},      32'd0);
      check_val("b2b_err0",    {31'h0, data_err},    32'd0);
      step();
      data_req = 1'b0;
      lat = -1;
      for (int c = 4; c < 40; c++) begin
         @(negedge clk);
         if (data_rvalid) begin
            lat = c;
            e   = data_err;
            break;
         end
         step();
      end
      check_val("b2b_lat1", lat, 32'd6);
      check_val("b2b_err1", {31'h0, e}, 32'd1);
      cfg_err_at = -1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
